// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter feeding NREQ requesters into one FIFO write port.
//   Ports: wclk/wrst (sync active-high reset), rq_valid/rq_data in, rq_ready/rq_gnt out,
//   wfull in, winc/wdata/wcount out.
//   Optional macro FIFO_ARB_WCOUNT_EN enables the 16-bit accepted-word counter on wcount;
//   without it wcount is tied to zero.
module fifo_wr_arb #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       rq_valid,
    input  logic [NREQ*DSIZE-1:0] rq_data,
    output logic [NREQ-1:0]       rq_ready,
    output logic [NREQ-1:0]       rq_gnt,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [15:0]           wcount
);
    localparam int SW = $clog2(NREQ);
    localparam int BW = BURST > 1 ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q;
    logic [SW-1:0]   sel_q, last_q, pick_d;
    logic [BW-1:0]   beat_q;
    logic [NREQ-1:0] gnt_q;
    logic            found_d;

    // First valid requester after the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        pick_d  = '0;
        found_d = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found_d && rq_valid[(int'(last_q) + k) % NREQ]) begin
                found_d = 1'b1;
                pick_d  = SW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    // gnt_q is only non-zero in BUSY, so it doubles as the state-qualified select.
    assign rq_gnt   = gnt_q;
    assign rq_ready = wfull ? '0 : gnt_q;
    assign winc     = |(rq_valid & rq_ready);
    assign wdata    = state_q == BUSY ? rq_data[sel_q*DSIZE +: DSIZE] : '0;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SW'(NREQ - 1);
            beat_q  <= '0;
            gnt_q   <= '0;
        end else if (state_q == IDLE) begin
            if (found_d) begin
                state_q <= BUSY;
                sel_q   <= pick_d;
                last_q  <= pick_d;
                beat_q  <= '0;
                gnt_q   <= NREQ'(1) << pick_d;
            end
        end else if (!rq_valid[sel_q] || (winc && beat_q == BW'(BURST - 1))) begin
            state_q <= IDLE;
            beat_q  <= '0;
            gnt_q   <= '0;
        end else if (winc) begin
            beat_q <= beat_q + 1'b1;
        end
    end

`ifdef FIFO_ARB_WCOUNT_EN
    logic [15:0] wcount_q;

    always_ff @(posedge wclk) begin
        if (wrst)
            wcount_q <= '0;
        else if (winc)
            wcount_q <= wcount_q + 16'd1;
    end

    assign wcount = wcount_q;
`else
    assign wcount = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed self-checking bench for fifo_wr_arb (NREQ=4, BURST=4, DSIZE=8).
module tb_fifo_wr_arb;
    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  rq_valid;
    logic [31:0] rq_data;
    logic [3:0]  rq_ready;
    logic [3:0]  rq_gnt;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [15:0] wcount;

    int nvec = 0;
    int nerr = 0;

    fifo_wr_arb #(.DSIZE(8), .NREQ(4), .BURST(4)) dut (
        .wclk(wclk), .wrst(wrst), .rq_valid(rq_valid), .rq_data(rq_data),
        .rq_ready(rq_ready), .rq_gnt(rq_gnt), .wfull(wfull), .winc(winc),
        .wdata(wdata), .wcount(wcount)
    );

    always #5 wclk = ~wclk;

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset;
        wrst = 1'b1;
        tick();
        wrst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rq_valid = 4'b0000;
        wfull    = 1'b0;
        do_reset();
        nvec++; if (rq_gnt !== 4'b0000) begin nerr++; $display("FAIL reset_gnt got %b want 0000", rq_gnt); end
        nvec++; if (rq_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready got %b want 0000", rq_ready); end
        nvec++; if (winc !== 1'b0) begin nerr++; $display("FAIL reset_winc got %b want 0", winc); end
        nvec++; if (wdata !== 8'h00) begin nerr++; $display("FAIL reset_wdata got %h want 00", wdata); end
        nvec++; if (wcount !== 16'd0) begin nerr++; $display("FAIL reset_wcount got %0d want 0", wcount); end
    endtask

    task automatic test_idle;
        do_reset();
        rq_valid = 4'b0000;
        tick();
        tick();
        nvec++; if (rq_gnt !== 4'b0000) begin nerr++; $display("FAIL idle_gnt got %b want 0000", rq_gnt); end
        nvec++; if (winc !== 1'b0) begin nerr++; $display("FAIL idle_winc got %b want 0", winc); end
    endtask

    task automatic test_single;
        do_reset();
        rq_valid = 4'b0001;
        tick();
        for (int b = 0; b < 4; b++) begin
            nvec++; if (rq_gnt !== 4'b0001) begin nerr++; $display("FAIL single_gnt beat %0d got %b want 0001", b, rq_gnt); end
            nvec++; if (rq_ready !== 4'b0001) begin nerr++; $display("FAIL single_ready beat %0d got %b want 0001", b, rq_ready); end
            nvec++; if (winc !== 1'b1) begin nerr++; $display("FAIL single_winc beat %0d got %b want 1", b, winc); end
            nvec++; if (wdata !== 8'hA0) begin nerr++; $display("FAIL single_wdata beat %0d got %h want a0", b, wdata); end
            tick();
        end
        nvec++; if (rq_gnt !== 4'b0000) begin nerr++; $display("FAIL single_bubble_gnt got %b want 0000", rq_gnt); end
        nvec++; if (winc !== 1'b0) begin nerr++; $display("FAIL single_bubble_winc got %b want 0", winc); end
        tick();
        nvec++; if (rq_gnt !== 4'b0001) begin nerr++; $display("FAIL single_regrant got %b want 0001", rq_gnt); end
    endtask

    task automatic test_round_robin;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        rq_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            for (int b = 0; b < 4; b++) begin
                nvec++; if (rq_gnt !== 4'(1 << order[g])) begin nerr++; $display("FAIL rr_gnt grant %0d beat %0d got %b want %b", g, b, rq_gnt, 4'(1 << order[g])); end
                nvec++; if (winc !== 1'b1) begin nerr++; $display("FAIL rr_winc grant %0d beat %0d got %b want 1", g, b, winc); end
                nvec++; if (wdata !== 8'(8'hA0 + order[g])) begin nerr++; $display("FAIL rr_wdata grant %0d beat %0d got %h want %h", g, b, wdata, 8'(8'hA0 + order[g])); end
                tick();
            end
            nvec++; if (rq_gnt !== 4'b0000) begin nerr++; $display("FAIL rr_bubble grant %0d got %b want 0000", g, rq_gnt); end
        end
    endtask

    task automatic test_wfull;
        do_reset();
        rq_valid = 4'b0100;
        tick();
        nvec++; if (winc !== 1'b1) begin nerr++; $display("FAIL full_beat1_winc got %b want 1", winc); end
        tick();
        wfull = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            nvec++; if (winc !== 1'b0) begin nerr++; $display("FAIL full_winc cycle %0d got %b want 0", c, winc); end
            nvec++; if (rq_ready !== 4'b0000) begin nerr++; $display("FAIL full_ready cycle %0d got %b want 0000", c, rq_ready); end
            nvec++; if (rq_gnt !== 4'b0100) begin nerr++; $display("FAIL full_gnt cycle %0d got %b want 0100", c, rq_gnt); end
            tick();
        end
        wfull = 1'b0;
        #1;
        for (int b = 2; b <= 4; b++) begin
            nvec++; if (rq_gnt !== 4'b0100) begin nerr++; $display("FAIL full_resume_gnt beat %0d got %b want 0100", b, rq_gnt); end
            nvec++; if (winc !== 1'b1) begin nerr++; $display("FAIL full_resume_winc beat %0d got %b want 1", b, winc); end
            nvec++; if (wdata !== 8'hA2) begin nerr++; $display("FAIL full_resume_wdata beat %0d got %h want a2", b, wdata); end
            tick();
        end
        nvec++; if (rq_gnt !== 4'b0000) begin nerr++; $display("FAIL full_end_gnt got %b want 0000", rq_gnt); end
    endtask

    task automatic test_drop;
        do_reset();
        rq_valid = 4'b0010;
        tick();
        nvec++; if (rq_gnt !== 4'b0010) begin nerr++; $display("FAIL drop_gnt got %b want 0010", rq_gnt); end
        tick();
        tick();
        rq_valid = 4'b0101;
        #1;
        nvec++; if (winc !== 1'b0) begin nerr++; $display("FAIL drop_winc got %b want 0", winc); end
        tick();
        nvec++; if (rq_gnt !== 4'b0000) begin nerr++; $display("FAIL drop_idle got %b want 0000", rq_gnt); end
        tick();
        nvec++; if (rq_gnt !== 4'b0100) begin nerr++; $display("FAIL drop_next_gnt got %b want 0100", rq_gnt); end
        nvec++; if (wdata !== 8'hA2) begin nerr++; $display("FAIL drop_next_wdata got %h want a2", wdata); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        rq_valid = 4'b0001;
        tick();
        tick();
        tick();
        nvec++; if (winc !== 1'b1) begin nerr++; $display("FAIL mid_beat3_winc got %b want 1", winc); end
        wrst = 1'b1;
        tick();
        wrst     = 1'b0;
        rq_valid = 4'b1000;
        #1;
        nvec++; if (rq_gnt !== 4'b0000) begin nerr++; $display("FAIL mid_gnt got %b want 0000", rq_gnt); end
        nvec++; if (winc !== 1'b0) begin nerr++; $display("FAIL mid_winc got %b want 0", winc); end
        nvec++; if (rq_ready !== 4'b0000) begin nerr++; $display("FAIL mid_ready got %b want 0000", rq_ready); end
        tick();
        nvec++; if (rq_gnt !== 4'b1000) begin nerr++; $display("FAIL mid_regrant got %b want 1000", rq_gnt); end
        nvec++; if (wdata !== 8'hA3) begin nerr++; $display("FAIL mid_wdata got %h want a3", wdata); end
    endtask

    task automatic test_wcount;
        int n = 0;
        int cyc = 0;
        logic [15:0] exp;
`ifdef FIFO_ARB_WCOUNT_EN
        exp = 16'd10;
`else
        exp = 16'd0;
`endif
        do_reset();
        rq_valid = 4'b0001;
        tick();
        while (n < 9 && cyc < 40) begin
            if (winc) n++;
            tick();
            cyc++;
        end
        while (!winc && cyc < 40) begin
            tick();
            cyc++;
        end
        nvec++; if (cyc >= 40) begin nerr++; $display("FAIL wcount_timeout got %0d cycles want under 40", cyc); end
        tick();
        rq_valid = 4'b0000;
        #1;
        nvec++; if (wcount !== exp) begin nerr++; $display("FAIL wcount got %0d want %0d", wcount, exp); end
    endtask

    initial begin
        wrst     = 1'b1;
        rq_valid = 4'b0000;
        rq_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        wfull    = 1'b0;
        test_reset();
        test_idle();
        test_single();
        test_round_robin();
        test_wfull();
        test_drop();
        test_reset_mid();
        test_wcount();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
